// File: rtl/usbf_scan_host.sv
// Scan-chain host: shifts a stimulus vector into the core and lets it settle.
// It then parallel-loads the response chain and shifts the captured vector back out.
module usbf_scan_host #(
  parameter int unsigned IN_W   = 125,
  parameter int unsigned OUT_W  = 121,
  parameter int unsigned DIV    = 2,
  parameter int unsigned SETTLE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IN_W-1:0]  in_vec_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] out_vec_o,
  output logic             shift_reg_clk_o,
  output logic             shift_reg_load_o,
  output logic             core_datain_o,
  input  logic             core_dataout_i
);

  localparam int unsigned MAXIO = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int unsigned MAXC  = (MAXIO > SETTLE) ? MAXIO : SETTLE;
  localparam int unsigned CW    = $clog2(MAXC + 1);
  localparam int unsigned PW    = $clog2(2 * DIV);

  localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] PH_CAP   = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HI    = PW'(DIV);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_W - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_W - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_IN, S_SETTLE, S_LOAD, S_SHIFT_OUT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IN_W-1:0]   buf_q, buf_d;
  logic [OUT_W-1:0]  outv_q, outv_d;
  logic              sclk_q, sclk_d;
  logic              load_q, load_d;
  logic              din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              period_end;

  assign period_end = (phase_q == PH_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    outv_d  = outv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SHIFT_IN;
          buf_d   = in_vec_i;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT_IN: begin
        if (period_end) begin
          phase_d = '0;
          buf_d   = {buf_q[IN_W-2:0], 1'b0};
          if (cnt_q == IN_LAST) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (period_end) begin
          state_d = S_SHIFT_OUT;
          phase_d = '0;
          cnt_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_SHIFT_OUT: begin
        // Chain tail is sampled just before the rising edge that would advance it.
        if (phase_q == PH_CAP) outv_d = {outv_q[OUT_W-2:0], core_dataout_i};
        if (period_end) begin
          phase_d = '0;
          if (cnt_q == OUT_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the upcoming state/phase.
    sclk_d = ((state_d == S_SHIFT_IN) || (state_d == S_LOAD) || (state_d == S_SHIFT_OUT))
             && (phase_d >= PH_HI);
    load_d = (state_d == S_LOAD);
    din_d  = (state_d == S_SHIFT_IN) && buf_d[IN_W-1];
    busy_d = (state_d == S_SHIFT_IN) || (state_d == S_SETTLE) ||
             (state_d == S_LOAD) || (state_d == S_SHIFT_OUT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      outv_q  <= '0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      outv_q  <= outv_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign out_vec_o        = outv_q;
  assign shift_reg_clk_o  = sclk_q;
  assign shift_reg_load_o = load_q;
  assign core_datain_o    = din_q;

endmodule

// File: tb/tb_usbf_scan_host.sv
// Bench for usbf_scan_host: two instances (default timing and DIV=1/SETTLE=1)
// driving a behavioural scan-chain core whose output j mirrors input j.
module tb_usbf_scan_host;

  localparam int IN_W  = 125;
  localparam int OUT_W = 121;
  localparam int NPER  = IN_W + 1 + OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, start, busy, done, sclk, load, din, dout;
  logic [IN_W-1:0]  inv [2];
  logic [OUT_W-1:0] outv [2];

  usbf_scan_host u_a (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .in_vec_i(inv[0]),
    .busy_o(busy[0]), .done_o(done[0]), .out_vec_o(outv[0]),
    .shift_reg_clk_o(sclk[0]), .shift_reg_load_o(load[0]),
    .core_datain_o(din[0]), .core_dataout_i(dout[0]));

  usbf_scan_host #(.DIV(1), .SETTLE(1)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .in_vec_i(inv[1]),
    .busy_o(busy[1]), .done_o(done[1]), .out_vec_o(outv[1]),
    .shift_reg_clk_o(sclk[1]), .shift_reg_load_o(load[1]),
    .core_datain_o(din[1]), .core_dataout_i(dout[1]));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scan-chain core model and transaction monitor
  logic [IN_W-1:0]  ichain [2];
  logic [OUT_W-1:0] ochain [2];
  logic [1:0] psclk = '0, pbusy = '0;
  int edges [2], loads [2], dones [2], acc_cyc [2], done_cyc [2];
  int dq [$];

  assign dout[0] = ochain[0][OUT_W-1];
  assign dout[1] = ochain[1][OUT_W-1];

  initial begin
    for (int i = 0; i < 2; i++) begin
      ichain[i] = '0; ochain[i] = '0;
      edges[i] = 0; loads[i] = 0; dones[i] = 0; acc_cyc[i] = 0; done_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !pbusy[i]) begin
        acc_cyc[i] = cyc; edges[i] = 0; loads[i] = 0;
      end
      if (sclk[i] && !psclk[i]) begin
        edges[i]++;
        if (load[i]) ochain[i] = ichain[i][OUT_W-1:0];
        else         ochain[i] = {ochain[i][OUT_W-2:0], 1'b0};
        ichain[i] = {ichain[i][IN_W-2:0], din[i]};
      end
      if (load[i]) loads[i]++;
      if (done[i]) begin
        dones[i]++; done_cyc[i] = cyc;
        if (i == 0) dq.push_back(cyc);
      end
      psclk[i] = sclk[i];
      pbusy[i] = busy[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_vec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[IN_W-1:0];
  endfunction

  // One transaction on instance i; optional stray start pulses while busy.
  task automatic txn(input int i, input logic [IN_W-1:0] v, input bit extra);
    int div, settle, base_d;
    bit got;
    div    = (i == 0) ? 2 : 1;
    settle = (i == 0) ? 16 : 1;
    base_d = dones[i];
    got    = 1'b0;
    @(negedge clk); #1;
    inv[i] = v; start[i] = 1'b1;
    for (int k = 1; k < 3000 && !got; k++) begin
      @(negedge clk); #1;
      start[i] = extra && (k == 10 || k == 500);
      if (dones[i] != base_d) got = 1'b1;
    end
    start[i] = 1'b0;
    chk("done_timeout", got, 1);
    repeat (20) @(negedge clk);
    #1;
    chk("done_count", dones[i], base_d + 1);
    // accept is observed in cycle T+1, done in cycle T+1+2*DIV*NPER+SETTLE
    chk("latency", done_cyc[i] - acc_cyc[i], 2 * div * NPER + settle);
    chk("shift_edges", edges[i], NPER);
    chk("load_cycles", loads[i], 2 * div);
    chk("out_vec", outv[i], v[OUT_W-1:0]);
    chk("busy_idle", busy[i], 0);
  endtask

  initial begin
    logic [IN_W-1:0] v;
    int d0, e0;
    bit got;
    rst = 2'b11; start = 2'b00; inv[0] = '0; inv[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl", {sclk[i], load[i], din[i], busy[i], done[i]}, 0);
      chk("rst_outv", outv[i], 0);
    end
    start = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("start_in_rst", busy, 0);
    start = 2'b00; rst = 2'b00;
    @(negedge clk);

    txn(0, '1, 1'b0);
    for (int j = 0; j < IN_W; j++) v[j] = (j % 2 == 1);
    txn(0, v, 1'b0);
    txn(0, rand_vec(), 1'b1);
    txn(1, rand_vec(), 1'b0);
    txn(1, rand_vec(), 1'b0);

    // Reset in SHIFT_IN period 60 while the shift clock is high
    @(negedge clk); #1;
    inv[0] = rand_vec(); start[0] = 1'b1;
    @(negedge clk); #1;
    start[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      if (edges[0] == 61) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("p60_timeout", got, 1);
    chk("p60_sclk_hi", sclk[0], 1);
    rst[0] = 1'b1;
    @(negedge clk); #1;
    chk("midrst_ctl", {sclk[0], load[0], din[0], busy[0], done[0]}, 0);
    chk("midrst_outv", outv[0], 0);
    rst[0] = 1'b0;
    d0 = dones[0]; e0 = edges[0];
    repeat (1100) @(negedge clk);
    #1;
    chk("midrst_no_done", dones[0], d0);
    chk("midrst_no_edges", edges[0], e0);
    txn(0, rand_vec(), 1'b0);

    // start held high: accepts only from IDLE
    dq.delete();
    @(negedge clk); #1;
    v = rand_vec();
    inv[0] = v; start[0] = 1'b1;
    repeat (2500) @(negedge clk);
    #1;
    start[0] = 1'b0;
    for (int k = 0; k < 3000 && dq.size() < 3; k++) @(negedge clk);
    #1;
    chk("b2b_count", dq.size(), 3);
    if (dq.size() >= 3) begin
      chk("b2b_gap1", dq[1] - dq[0], 1006);
      chk("b2b_gap2", dq[2] - dq[1], 1006);
    end
    chk("b2b_outv", outv[0], v[OUT_W-1:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usbf_scan_host.md
USBF_SCAN_HOST -- requirements
Module: usbf_scan_host

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  IN_W  125  scan-input chain length in bits (stimulus vector).
  OUT_W  121  scan-output chain length in bits (capture vector).
  DIV  2  shift clock half-period in clk_i cycles, range 1..255.
  SETTLE  16  clk_i cycles the core runs between shift-in and load, range 1..65535.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_i  in  1  sole clock; every flop on rising edge.
  rst_i  in  1  synchronous reset, active-high.
  start_i  in  1  request one scan transaction.
  in_vec_i  in  IN_W  stimulus; in_vec_i[j] ends at scan-input position j.
  busy_o  out  1  transaction in progress.
  done_o  out  1  one-cycle completion pulse.
  out_vec_o  out  OUT_W  captured response; out_vec_o[j] = scan-output position j.
  shift_reg_clk_o  out  1  generated shift clock to the scan chain.
  shift_reg_load_o  out  1  parallel-load select for the output chain.
  core_datain_o  out  1  serial stimulus bit.
  core_dataout_i  in  1  serial response bit (chain tail, position OUT_W-1).

Function
REQ-003 SHALL implement FSM states IDLE, SHIFT_IN, SETTLE, LOAD, SHIFT_OUT, DONE.
REQ-004 The shift-clock period SHALL be 2*DIV clk_i cycles: phase cycles 0..DIV-1 low, DIV..2*DIV-1 high; all outputs driven from flops.
REQ-005 IDLE: on start_i=1, SHALL latch in_vec_i into a shift buffer, set busy_o=1 on the next cycle, and enter SHIFT_IN; start_i while busy_o=1 SHALL be ignored.
REQ-006 SHIFT_IN: IN_W shift periods; period k SHALL drive core_datain_o = in_vec_i[IN_W-1-k] from phase cycle 0 through the period end; shift_reg_load_o=0.
REQ-007 SETTLE: shift_reg_clk_o held low, core_datain_o=0, for exactly SETTLE cycles.
REQ-008 LOAD: exactly one shift period with shift_reg_load_o=1 for the whole period; core_datain_o=0.
REQ-009 SHIFT_OUT: OUT_W periods with load=0 and core_datain_o=0; in period m, SHALL sample core_dataout_i at phase cycle DIV-1 into out_vec_o[OUT_W-1-m].
REQ-010 Stimulus is disturbed by LOAD/SHIFT_OUT edges by design; capture occurs on the LOAD rising edge, before any disturbance.
REQ-011 out_vec_o SHALL update bit-serially during SHIFT_OUT and hold its value from DONE until the next SHIFT_OUT begins.
REQ-012 DONE: single cycle; done_o=1 and busy_o=0 in that cycle; return to IDLE.
REQ-013 Latency: with start_i sampled at cycle T, done_o SHALL assert at cycle T+1+2*DIV*(IN_W+1+OUT_W)+SETTLE (defaults: T+1005).
REQ-014 Exactly IN_W+1+OUT_W rising edges of shift_reg_clk_o SHALL occur per transaction; none occur in IDLE, SETTLE, or DONE.
REQ-015 Period and bit counters SHALL be sized for the parameters and SHALL NOT wrap within a transaction.
REQ-016 start_i asserted in the DONE cycle SHALL be ignored; a new transaction is accepted from IDLE only.

Reset
REQ-017 With rst_i=1 at a clock edge: state IDLE, busy_o=0, done_o=0, shift_reg_clk_o=0, shift_reg_load_o=0, core_datain_o=0, out_vec_o=0, all counters 0.
REQ-018 Reset in any state, including mid-period with shift_reg_clk_o high, SHALL take effect at that edge, with no further shift edges and no done_o pulse.
REQ-019 start_i SHALL be ignored while rst_i=1.

Verification
Bench model: scan chain as specified, with core_output[j] = core_input[j] for j<OUT_W.
REQ-020 Defaults, in_vec_i all ones -> out_vec_o all ones; done_o at T+1005; 247 shift_reg_clk_o rising edges counted.
REQ-021 in_vec_i alternating 1010... (bit0=0) -> out_vec_o[j] = in_vec_i[j] for j=0..120; load high for exactly 4 cycles.
REQ-022 start_i pulsed again 10 and 500 cycles after the first accept -> ignored; single done_o; edge count still 247.
REQ-023 rst_i asserted during SHIFT_IN period 60 -> next cycle all outputs at reset values; no done_o; a fresh start then completes correctly.
REQ-024 DIV=1, SETTLE=1, random in_vec_i -> done_o at T+1+2*247+1 = T+496; out_vec_o matches model.
REQ-025 Back-to-back: start_i held high continuously -> transactions accepted only from IDLE, done_o spaced by 1006 cycles (defaults).
